// File: rtl/exhaustive_vector_checker.sv
// Walks all 2^N_IN input vectors, holds each for STEP_CYCLES+1 cycles and compares two implementations.
// Optional macro STOP_ON_FAIL_EN: end the sweep on the first mismatching vector.
module exhaustive_vector_checker #(
  parameter int N_IN        = 4,
  parameter int N_OUT       = 2,
  parameter int STEP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_OUT-1:0] ref_in,
  input  logic [N_OUT-1:0] dut_in,
  output logic [N_IN-1:0]  vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_IN:0]    err_count,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_vec
);

  // state  | meaning
  // S_IDLE | after reset, waiting for start
  // S_RUN  | sweeping vectors; compare on the last settle cycle of each vector
  // S_DONE | sweep finished, results held until the next start

  localparam int SW = (STEP_CYCLES > 0) ? $clog2(STEP_CYCLES + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(STEP_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [N_IN:0]   err_q, err_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;
  logic            pass_q, pass_d;
  logic            mismatch;
  logic            stop_now;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffvec_d  = ffvec_q;
    pass_d   = pass_q;
    mismatch = 1'b0;
    stop_now = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          vec_d    = '0;
          settle_d = '0;
          err_d    = '0;
          ffv_d    = 1'b0;
          ffvec_d  = '0;
          pass_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (settle_q != SETTLE_LAST) begin
          settle_d = settle_q + 1'b1;
        end else begin
          mismatch = (ref_in != dut_in);
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = vec_q;
            end
          end
`ifdef STOP_ON_FAIL_EN
          stop_now = mismatch;
`else
          stop_now = 1'b0;
`endif
          if (stop_now) begin
            state_d = S_DONE;
            pass_d  = 1'b0;
          end else if (vec_q != '1) begin
            vec_d    = vec_q + 1'b1;
            settle_d = '0;
          end else begin
            // pass reflects the count including the final vector's compare
            state_d = S_DONE;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      ffv_q    <= 1'b0;
      ffvec_q  <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffvec_q  <= ffvec_d;
      pass_q   <= pass_d;
    end
  end

  assign vec_out          = vec_q;
  assign busy             = (state_q == S_RUN);
  assign done             = (state_q == S_DONE);
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Bench for exhaustive_vector_checker: two instances (STEP_CYCLES=1 and 0), random truth tables and
// mismatch maps, results predicted from the set of mismatching vectors.
module tb_exhaustive_vector_checker;
  localparam int NI = 4;
  localparam int NO = 2;
  localparam int NV = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start_a, start_b, sel;
  logic [NO-1:0] tbl [NV];
  logic [NV-1:0] mis_a, mis_b;
  logic [NO-1:0] flip;

  logic [NI-1:0] vec_a, vec_b, ffvec_a, ffvec_b;
  logic          busy_a, busy_b, done_a, done_b, pass_a, pass_b, ffv_a, ffv_b;
  logic [NI:0]   err_a, err_b;
  logic [NO-1:0] ref_a, dut_a, ref_b, dut_b;

  assign ref_a = tbl[vec_a];
  assign dut_a = ref_a ^ (mis_a[vec_a] ? flip : '0);
  assign ref_b = tbl[vec_b];
  assign dut_b = ref_b ^ (mis_b[vec_b] ? flip : '0);

  exhaustive_vector_checker #(.N_IN(NI), .N_OUT(NO), .STEP_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .ref_in(ref_a), .dut_in(dut_a),
    .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_fail_valid(ffv_a), .first_fail_vec(ffvec_a));

  exhaustive_vector_checker #(.N_IN(NI), .N_OUT(NO), .STEP_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .ref_in(ref_b), .dut_in(dut_b),
    .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_fail_valid(ffv_b), .first_fail_vec(ffvec_b));

  logic [NI-1:0] vec_m, ffvec_m;
  logic          busy_m, done_m, pass_m, ffv_m;
  logic [NI:0]   err_m;
  assign vec_m   = sel ? vec_b   : vec_a;
  assign ffvec_m = sel ? ffvec_b : ffvec_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign pass_m  = sel ? pass_b  : pass_a;
  assign ffv_m   = sel ? ffv_b   : ffv_a;
  assign err_m   = sel ? err_b   : err_a;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vec"},   vec_m,   0);
    chk({tag, "_busy"},  busy_m,  0);
    chk({tag, "_done"},  done_m,  0);
    chk({tag, "_pass"},  pass_m,  0);
    chk({tag, "_err"},   err_m,   0);
    chk({tag, "_ffv"},   ffv_m,   0);
    chk({tag, "_ffvec"}, ffvec_m, 0);
  endtask

  // One full sweep on the selected instance; p1/p2 are busy-cycle indices where start is re-pulsed.
  task automatic sweep(input string nm, input int steps, input logic [NV-1:0] mis,
                       input int p1, input int p2);
    int exp_err, exp_ffv, exp_ffvec, last, exp_cyc, cnt, vec_bad;
    exp_err = 0; exp_ffv = 0; exp_ffvec = 0; last = NV - 1;
    for (int v = 0; v < NV; v++) begin
      if (mis[v]) begin
        exp_err++;
        if (exp_ffv == 0) begin
          exp_ffv   = 1;
          exp_ffvec = v;
        end
`ifdef STOP_ON_FAIL_EN
        last = v;
        break;
`endif
      end
    end
    exp_cyc = (last + 1) * (steps + 1);
    if (sel) mis_b = mis;
    else     mis_a = mis;

    set_start(1'b1);
    tick();
    set_start(1'b0);
    chk({nm, "_start_busy"}, busy_m, 1);
    chk({nm, "_start_done"}, done_m, 0);
    chk({nm, "_start_err"},  err_m,  0);
    chk({nm, "_start_ffv"},  ffv_m,  0);
    cnt = 0; vec_bad = 0;
    while (busy_m === 1'b1 && cnt < 4 * NV * (steps + 1) + 10) begin
      if (vec_m !== NI'(cnt / (steps + 1))) vec_bad++;
      set_start((cnt == p1) || (cnt == p2));
      tick();
      cnt++;
    end
    set_start(1'b0);
    chk({nm, "_busy_cycles"}, cnt, exp_cyc);
    chk({nm, "_vec_order_errs"}, vec_bad, 0);
    chk({nm, "_done"},  done_m,  1);
    chk({nm, "_pass"},  pass_m,  (exp_err == 0) ? 1 : 0);
    chk({nm, "_err"},   err_m,   exp_err);
    chk({nm, "_ffv"},   ffv_m,   exp_ffv);
    if (exp_ffv != 0) chk({nm, "_ffvec"}, ffvec_m, exp_ffvec);
    chk({nm, "_vec_hold"}, vec_m, last);
  endtask

  initial begin
    int cnt;
    logic [NV-1:0] m;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    mis_a = '0; mis_b = '0; flip = 2'b01;
    for (int i = 0; i < NV; i++) tbl[i] = NO'($urandom);
    tick();
    rst = 1'b0;
    chk_zero("reset_a");
    sel = 1'b1;
    chk_zero("reset_b");
    sel = 1'b0;

    sweep("clean", 1, '0, -1, -1);

    flip = 2'b01;
    sweep("mis_5_10", 1, 16'h0420, -1, -1);

    sel = 1'b1;
    flip = 2'b10;
    sweep("s0_last", 0, 16'h8000, -1, -1);
    sel = 1'b0;

    for (int k = 0; k < 4; k++) begin
      m = NV'($urandom) & NV'($urandom);
      flip = NO'($urandom_range(1, 3));
      for (int i = 0; i < NV; i++) tbl[i] = NO'($urandom);
      sweep("rand_a", 1, m, -1, -1);
      sel = 1'b1;
      sweep("rand_b", 0, m ^ NV'($urandom), -1, -1);
      sel = 1'b0;
    end

    mis_a = '0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cnt = 0;
    while (vec_a !== 4'd7 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("mid_reached_7", vec_a, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero("mid_reset");
    sweep("after_reset", 1, NV'($urandom) | 16'h0100, -1, -1);

    flip = 2'b11;
    sweep("pulses", 1, 16'h0a12, 3, 20);
    sweep("restart_from_done", 1, '0, -1, -1);

    start_a = 1'b1;
    cnt = 0;
    while (busy_a !== 1'b1 && cnt < 10) begin
      tick();
      cnt++;
    end
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("held_busy_cycles", cnt, 32);
    chk("held_done_gap", done_a, 1);
    tick();
    chk("held_restart_busy", busy_a, 1);
    chk("held_restart_done", done_a, 0);
    chk("held_restart_vec", vec_a, 0);
    start_a = 1'b0;
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 100) begin
      tick();
      cnt++;
    end
    chk("held_final_done", done_a, 1);
    chk("held_final_pass", pass_a, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exhaustive_vector_checker.md
Name: exhaustive_vector_checker

Overview:
- Self-checking stimulus engine for combinational truth-table verification.
- Walks every 2^N_IN input combination on vec_out and holds each vector for a programmable settle time.
- Compares two N_OUT-bit implementations of the same function (e.g. gate-level vs UDP) and reports pass/fail, mismatch count and first failing vector.
- Replaces hand-written per-vector stimulus blocks in unit benches; synthesisable for on-FPGA self-test.

Parameters:
- N_IN, 4, number of function inputs; vector space is 2^N_IN (legal 1..16).
- N_OUT, 2, number of outputs compared per vector (legal ≥1).
- STEP_CYCLES, 1, settle cycles per vector before the compare cycle (legal ≥0).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE or DONE.
- ref_in  input  N_OUT  outputs of the reference implementation for the current vec_out.
- dut_in  input  N_OUT  outputs of the implementation under check for the current vec_out.
- vec_out  output  N_IN  registered stimulus vector driving both implementations.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- pass  output  1  valid while done; 1 means zero mismatches.
- err_count  output  N_IN+1  number of mismatching vectors; cannot overflow.
- first_fail_valid  output  1  high once any mismatch has been recorded.
- first_fail_vec  output  N_IN  value of vec_out at the first mismatch.

Behaviour:
- Reset: one cycle with rst=1 forces state IDLE and clears all outputs and internal counters to 0. Reset wins over every other event, including mid-sweep.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1, at edge E:
  - state goes to RUN; vec_out=0; settle_cnt=0; busy=1; done=0.
  - pass, err_count, first_fail_valid and first_fail_vec are cleared.
- RUN, settle phase: each vector is held for STEP_CYCLES+1 cycles. settle_cnt increments each cycle.
- RUN, compare cycle (settle_cnt==STEP_CYCLES), at the closing edge:
  - If ref_in != dut_in (any bit), err_count increments.
  - If that is the first mismatch, first_fail_valid is set to 1 and first_fail_vec takes vec_out. Later mismatches do not change these two outputs.
  - If vec_out != 2^N_IN-1: vec_out increments and settle_cnt returns to 0.
  - If vec_out == 2^N_IN-1: state goes to DONE; busy=0; done=1; pass=(final err_count==0), including a mismatch on the last vector. vec_out holds its last value.
- Latency: busy is high for exactly 2^N_IN*(STEP_CYCLES+1) cycles.
- start while in RUN is ignored.
- start held high continuously: the block restarts immediately after each DONE, with one DONE cycle between sweeps.
- ref_in and dut_in are ignored outside compare cycles.
- Inputs X/Z on a compare cycle: either a mismatch or a match is acceptable. Benches must not rely on the result.

Optional Feature:
- Macro: STOP_ON_FAIL_EN.
- Defined: on the first mismatching compare cycle the FSM goes directly to DONE with busy=0, done=1, pass=0, err_count=1, first_fail_valid=1, first_fail_vec=failing vector, and vec_out held at that vector.
- Undefined: the sweep always completes all 2^N_IN vectors as described above.

Test Plan:
- Defaults (N_IN=4, N_OUT=2, STEP_CYCLES=1), dut_in tied to ref_in, pulse start -> vec_out steps 0..15, each held 2 cycles; busy high 32 cycles; then done=1, pass=1, err_count=0, first_fail_valid=0.
- Defaults, dut_in bit 0 inverted when vec_out==5 or vec_out==10 -> done=1, pass=0, err_count=2, first_fail_valid=1, first_fail_vec=5.
- STEP_CYCLES=0, mismatch only at vec_out==15 -> busy high 16 cycles, err_count=1, first_fail_vec=15, pass=0.
- Defaults, rst=1 for one cycle when vec_out==7, then start again -> all outputs 0 after the reset edge; the new sweep restarts at vec_out=0 and completes in 32 cycles with correct counts.
- Defaults, start pulsed at busy cycles 3 and 20, then again in DONE -> mid-sweep pulses ignored; the pulse in DONE restarts the sweep and clears err_count and first_fail_valid on the same edge.
- STOP_ON_FAIL_EN defined, mismatch at vec_out==3 -> DONE after 8 busy cycles, err_count=1, vec_out=3, pass=0.
